result_collector: RTL

Output-side stage placed directly downstream of the multi-core matrix-multiply top. It captures each `NUM_CORES`-wide result word, presented with a one-cycle valid pulse when the accumulators finish. Captured words are buffered in a small FIFO and re-emitted as a ready/valid stream with a sequential word index and a last marker. After exactly `NUM_WORDS` words have been delivered it raises `done`.

---
 rtl/collector_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/result_collector.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/collector_pkg.sv
// Shared types and helpers for the result_collector stage.
package collector_pkg;

  // Collection sequence: wait for start, capture words, drain the buffer, report done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of one result word coming out of the multiply top.
  function automatic int dw(input int width, input int chunk_size, input int num_cores);
    return width * chunk_size * num_cores;
  endfunction

  // Pointer width for a power-of-two buffer; occupancy counts use one extra bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with async reset and a synchronous flush.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo
  import collector_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A full buffer still takes a push when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointer and occupancy values; flush wins over any traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; stale contents are never visible because readers qualify on occupancy.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/result_collector.sv
// Captures result words from the multiply top, buffers them and re-emits them
// as an indexed ready/valid stream; raises done after NUM_WORDS deliveries.
// Optional feature macro: RESULT_COLLECTOR_OVF_EN (sticky overflow detection,
// dropped words still counted and padded with the last pushed word).
module result_collector
  import collector_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int CHUNK_SIZE = 4,
  parameter  int NUM_CORES  = 2,
  parameter  int NUM_WORDS  = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int IDX_WIDTH  = 14,
  localparam int DW         = dw(WIDTH, CHUNK_SIZE, NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic [IDX_WIDTH-1:0] m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int                   CNT_W    = ptr_w(FIFO_DEPTH) + 1;
  localparam logic [IDX_WIDTH-1:0] NW       = IDX_WIDTH'(NUM_WORDS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] accept_cnt_q, accept_cnt_d;
  logic [IDX_WIDTH-1:0] emit_cnt_q, emit_cnt_d;
  logic                 fifo_flush, fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [DW-1:0]        fifo_dout;
  logic                 fill_active;
  logic                 handshake;
`ifdef RESULT_COLLECTOR_OVF_EN
  logic                 overflow_q, overflow_d;
  logic [DW-1:0]        last_word_q, last_word_d;
`endif

  sync_fifo #(
    .WIDTH(DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(fifo_flush),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef RESULT_COLLECTOR_OVF_EN
  // Once draining, words lost to overflow are replaced by repeats of the last stored word.
  assign fill_active = (state_q == ST_DRAIN) && fifo_empty && (emit_cnt_q != NW);
  assign m_data      = !m_valid ? '0 : (fifo_empty ? last_word_q : fifo_dout);
  assign overflow    = overflow_q;
`else
  assign fill_active = 1'b0;
  assign m_data      = m_valid ? fifo_dout : '0;
  assign overflow    = 1'b0;
`endif

  // Stream outputs decode registered state only; m_data is forced to zero when idle.
  assign m_valid   = (fifo_count != '0) || fill_active;
  assign handshake = m_valid && m_ready;
  assign fifo_pop  = handshake && !fifo_empty;
  assign m_index   = emit_cnt_q;
  assign m_last    = m_valid && (emit_cnt_q == LAST_IDX);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // Sequencing, counters and capture decisions.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    accept_cnt_d = accept_cnt_q;
    emit_cnt_d   = emit_cnt_q;
    fifo_flush   = 1'b0;
    fifo_push    = 1'b0;
`ifdef RESULT_COLLECTOR_OVF_EN
    overflow_d   = overflow_q;
    last_word_d  = last_word_q;
`endif
    if (handshake) emit_cnt_d = emit_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          accept_cnt_d = '0;
          emit_cnt_d   = '0;
          fifo_flush   = 1'b1;
`ifdef RESULT_COLLECTOR_OVF_EN
          overflow_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (!fifo_full || fifo_pop) begin
            fifo_push    = 1'b1;
            accept_cnt_d = accept_cnt_q + 1'b1;
`ifdef RESULT_COLLECTOR_OVF_EN
            last_word_d  = in_data;
`endif
          end
`ifdef RESULT_COLLECTOR_OVF_EN
          else begin
            overflow_d   = 1'b1;
            accept_cnt_d = accept_cnt_q + 1'b1;
          end
`endif
        end
        if (accept_cnt_d == NW) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handshake && (emit_cnt_q == LAST_IDX)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      accept_cnt_q <= '0;
      emit_cnt_q   <= '0;
`ifdef RESULT_COLLECTOR_OVF_EN
      overflow_q   <= 1'b0;
      last_word_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      accept_cnt_q <= accept_cnt_d;
      emit_cnt_q   <= emit_cnt_d;
`ifdef RESULT_COLLECTOR_OVF_EN
      overflow_q   <= overflow_d;
      last_word_q  <= last_word_d;
`endif
    end
  end

endmodule
